// File: rtl/mem_rmw_ctrl_if.sv
// Requester and data-RAM signal bundle for the MEM-stage RAM sequencer.
// slave = the controller's view; master = the pipeline/RAM environment's view.
interface mem_rmw_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [DATA_W/8-1:0]   sel_i;
  logic [ADDR_W-1:0]     addr_i;
  logic [DATA_W-1:0]     data_i;
  logic                  ack_o;
  logic [DATA_W-1:0]     data_o;
  logic                  stall_o;
  logic                  ram_we_o;
  logic [ADDR_W-1:0]     ram_addr_o;
  logic [DATA_W-1:0]     ram_data_o;
  logic [DATA_W-1:0]     ram_data_i;

  modport slave (
    input  req_i, we_i, sel_i, addr_i, data_i, ram_data_i,
    output ack_o, data_o, stall_o, ram_we_o, ram_addr_o, ram_data_o
  );

  modport master (
    output req_i, we_i, sel_i, addr_i, data_i, ram_data_i,
    input  ack_o, data_o, stall_o, ram_we_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Sequences a single-port word-wide data RAM: word loads, direct full-word stores,
// and read-modify-write for byte/halfword stores (the RAM has no byte enables).
module mem_rmw_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_rmw_ctrl_if.slave  bus
);
  localparam int LANES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LANES-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic [DATA_W-1:0]   merge_w;

  // Lane merge of the store data over the word currently being read back.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
    assign merge_w[gi*8 +: 8] = sel_q[gi] ? data_q[gi*8 +: 8] : bus.ram_data_i[gi*8 +: 8];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    dout_d     = '0;
    ram_we_d   = 1'b0;
    ram_addr_d = '0;
    ram_data_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          addr_d = bus.addr_i;
          data_d = bus.data_i;
          sel_d  = bus.sel_i;
          we_d   = bus.we_i;
          if (!bus.we_i) begin
            state_d    = READ;
            ram_addr_d = bus.addr_i & WORD_MASK;
          end else if (bus.sel_i == '1) begin
            state_d    = WRITE;
            ram_we_d   = 1'b1;
            ram_addr_d = bus.addr_i & WORD_MASK;
            ram_data_d = bus.data_i;
          end else if (bus.sel_i == '0) begin
            state_d = RESP;
            ack_d   = 1'b1;
          end else begin
            state_d    = READ;
            ram_addr_d = bus.addr_i & WORD_MASK;
          end
        end
      end
      READ: begin
        rdata_d = bus.ram_data_i;
        if (we_q) begin
          // Outputs are registered, so the merged word is formed from the live read data.
          state_d    = WRITE;
          ram_we_d   = 1'b1;
          ram_addr_d = addr_q & WORD_MASK;
          ram_data_d = merge_w;
        end else begin
          state_d = RESP;
          ack_d   = 1'b1;
          dout_d  = bus.ram_data_i;
        end
      end
      WRITE: begin
        state_d = RESP;
        ack_d   = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Async reset clears ram_we immediately so an in-flight write never commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.data_o     = dout_q;
  assign bus.stall_o    = bus.req_i & ~ack_q;
  assign bus.ram_we_o   = ram_we_q;
  assign bus.ram_addr_o = ram_addr_q;
  assign bus.ram_data_o = ram_data_q;
endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Scoreboard bench for mem_rmw_ctrl: a driver queues expected acks, a negedge monitor checks them,
// and a small word RAM model with combinational read sits on the ram_* side.
module tb_mem_rmw_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_rmw_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_rmw_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (bus.ram_we_o) begin
      mem[bus.ram_addr_o[7:2]] <= bus.ram_data_o;
      wr_count <= wr_count + 1;
    end
  end

  assign bus.ram_data_i = bus.ram_we_o ? 32'h0 : mem[bus.ram_addr_o[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: pops one expectation per ack and checks data and latency.
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ram_we_o)
        chk("ram_addr_in_range", {bus.ram_addr_o[31:8], bus.ram_addr_o[1:0]}, 32'h0);
      if (bus.ack_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got data_o %h expected no ack (cycle %0d)", bus.data_o, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("ack_data", bus.data_o, e.data);
          chk("ack_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end else if (bus.data_o !== 32'h0) begin
        chk("data_o_idle_zero", bus.data_o, 32'h0);
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic idle();
    bus.req_i = 1'b0;
    @(negedge clk);
  endtask

  // Issues one request; inputs are scrambled after accept to prove the latched copy is used.
  task automatic run_op(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_d,
                        input int lat, input int nwr, input bit chained);
    int acc;
    int w0;
    bit got;
    bus.we_i = we; bus.sel_i = sel; bus.addr_i = addr; bus.data_i = data; bus.req_i = 1'b1;
    acc = chained ? cyc + 2 : cyc + 1;
    sb_q.push_back('{exp_d, lat, acc});
    w0 = wr_count;
    for (int i = 0; i < 8 && cyc < acc; i++) @(negedge clk);
    bus.we_i = ~we; bus.sel_i = ~sel; bus.addr_i = ~addr; bus.data_i = ~data;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ack_o) begin
        got = 1'b1;
        break;
      end
      chk("stall_busy", 32'(bus.stall_o), 32'h1);
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within %0d cycles", lat);
    end else
      chk("stall_at_ack", 32'(bus.stall_o), 32'h0);
    chk("ram_write_count", 32'(wr_count - w0), 32'(nwr));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"},      32'(bus.ack_o),    32'h0);
    chk({tag, "_data_o"},   bus.data_o,        32'h0);
    chk({tag, "_ram_we"},   32'(bus.ram_we_o), 32'h0);
    chk({tag, "_ram_addr"}, bus.ram_addr_o,    32'h0);
    chk({tag, "_ram_data"}, bus.ram_data_o,    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.sel_i = '0; bus.addr_i = '0; bus.data_i = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_stall", 32'(bus.stall_o), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    preload(6'd4,  32'h1122_3344);
    preload(6'd8,  32'h0000_0000);
    preload(6'd12, 32'h1122_3344);
    preload(6'd16, 32'h1122_3344);

    // Loads and full-word stores
    run_op(1'b0, 4'hF, 32'h10, 32'h0, 32'h1122_3344, 2, 0, 1'b0); idle();
    run_op(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, 32'h0, 2, 1, 1'b0); idle();
    chk("mem_0x20_full_store", mem[8], 32'hDEAD_BEEF);
    run_op(1'b0, 4'hF, 32'h20, 32'h0, 32'hDEAD_BEEF, 2, 0, 1'b0); idle();

    // Partial stores
    run_op(1'b1, 4'b0010, 32'h10, 32'h0000_AB00, 32'h0, 3, 1, 1'b0); idle();
    chk("mem_0x10_byte1", mem[4], 32'h1122_AB44);
    run_op(1'b1, 4'b1100, 32'h43, 32'hCAFE_0000, 32'h0, 3, 1, 1'b0); idle();
    chk("mem_0x40_half_hi", mem[16], 32'hCAFE_3344);
    run_op(1'b1, 4'b0000, 32'h40, 32'hFFFF_FFFF, 32'h0, 1, 0, 1'b0); idle();
    chk("mem_0x40_sel0", mem[16], 32'hCAFE_3344);
    run_op(1'b1, 4'b0101, 32'h40, 32'h00AA_00BB, 32'h0, 3, 1, 1'b0); idle();
    chk("mem_0x40_sel0101", mem[16], 32'hCAAA_33BB);

    // Reset asserted during the WRITE cycle of a partial store
    bus.we_i = 1'b1; bus.sel_i = 4'b0010; bus.addr_i = 32'h30; bus.data_i = 32'h0000_AB00;
    bus.req_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midwrite_ram_we", 32'(bus.ram_we_o), 32'h1);
    chk("midwrite_ram_data", bus.ram_data_o, 32'h1122_AB44);
    w0 = wr_count;
    rst = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    bus.req_i = 1'b0;
    @(negedge clk);
    chk("mem_0x30_no_commit", mem[12], 32'h1122_3344);
    chk("rst_write_count", 32'(wr_count - w0), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("after_rst");
    run_op(1'b0, 4'hF, 32'h30, 32'h0, 32'h1122_3344, 2, 0, 1'b0); idle();

    // Back-to-back with req_i held high
    run_op(1'b0, 4'hF, 32'h10, 32'h0, 32'h1122_AB44, 2, 0, 1'b0);
    run_op(1'b1, 4'hF, 32'h24, 32'h5566_7788, 32'h0, 2, 1, 1'b1);
    run_op(1'b0, 4'hF, 32'h24, 32'h0, 32'h5566_7788, 2, 0, 1'b1);
    idle();
    chk("mem_0x24_b2b", mem[9], 32'h5566_7788);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
